voice_mix_sequencer: RTL and testbench

//   Time-multiplexed mixer for the FM synthesizer voice bank. On each sample tick it walks
//   the active voices in index order, requests each voice's Q4.14 sample over a req/ack

---
 rtl/voice_mix_sequencer.sv | 118 +++++++++++
 tb/tb_voice_mix_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/voice_mix_sequencer.sv
// Time-multiplexed voice mixer: walks the active voices one at a time over a req/ack
// handshake and accumulates their samples into a single Q8.16 mix per sample tick.
//
// state | meaning
// IDLE  | waiting for sample_tick
// SCAN  | pick lowest pending voice, or finish the frame when none remain
// REQ   | voice_req high, waiting for ack or timeout
// DONE  | mix_valid strobe, mix_out just updated
module voice_mix_sequencer #(
  parameter int NUM_VOICES   = 16,
  parameter int NUM_BITS_IN  = 18,
  parameter int NUM_BITS_OUT = 24,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_tick,
  input  logic [NUM_VOICES-1:0]   voice_active,
  output logic                    voice_req,
  output logic [3:0]              voice_sel,
  input  logic                    voice_ack,
  input  logic [NUM_BITS_IN-1:0]  voice_data,
  output logic [NUM_BITS_OUT-1:0] mix_out,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = NUM_BITS_IN + IDX_W;
  localparam int PAD_W = NUM_BITS_OUT - ACC_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;

  state_t                  state;
  logic [NUM_VOICES-1:0]   pend_mask;
  logic signed [ACC_W-1:0] acc;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [IDX_W-1:0]        cur_idx;
  logic [IDX_W-1:0]        low_idx;
  logic [ACC_W-1:0]        data_ext;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (pend_mask[i]) low_idx = IDX_W'(i);
    end
  end

  assign data_ext  = {{IDX_W{voice_data[NUM_BITS_IN-1]}}, voice_data};
  assign voice_sel = 4'(cur_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_mask   <= '0;
      acc         <= '0;
      tmo_cnt     <= '0;
      cur_idx     <= '0;
      voice_req   <= 1'b0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mix_valid   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= sample_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_tick) begin
            pend_mask <= voice_active;
            acc       <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (pend_mask == '0) begin
            mix_out   <= {acc, {PAD_W{1'b0}}};
            mix_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cur_idx   <= low_idx;
            tmo_cnt   <= TMO_W'(TIMEOUT - 1);
            voice_req <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          // Ack wins over an expiring timer on the same edge.
          if (voice_ack) begin
            acc                <= acc + $signed(data_ext);
            pend_mask[cur_idx] <= 1'b0;
            voice_req          <= 1'b0;
            state              <= SCAN;
          end else if (tmo_cnt == '0) begin
            timeout_err        <= 1'b1;
            pend_mask[cur_idx] <= 1'b0;
            voice_req          <= 1'b0;
            state              <= SCAN;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Bench for voice_mix_sequencer: a voice-bank model answers requests with per-voice data
// and ack delays; each frame is checked against sums and cycle counts from a frame model.
module tb_voice_mix_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] voice_active = '0;
  logic        voice_req;
  logic [3:0]  voice_sel;
  logic        voice_ack = 1'b0;
  logic [17:0] voice_data = '0;
  logic [23:0] mix_out;
  logic        mix_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  logic [17:0] data_tbl [16];
  int          dly_tbl  [16];
  int          visits [$];
  int          req_cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] last_mix = '0;

  voice_mix_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .voice_active(voice_active),
    .voice_req(voice_req), .voice_sel(voice_sel), .voice_ack(voice_ack),
    .voice_data(voice_data), .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Voice bank: acks voice v after dly_tbl[v] cycles of request; junk ack/data otherwise.
  always @(negedge clk) begin
    if (voice_req) begin
      if (req_cyc == 0) visits.push_back(int'(voice_sel));
      if (req_cyc == dly_tbl[voice_sel]) begin
        voice_ack  = 1'b1;
        voice_data = data_tbl[voice_sel];
      end else begin
        voice_ack  = 1'b0;
        voice_data = 18'($urandom);
      end
      req_cyc++;
    end else begin
      voice_ack  = 1'($urandom);
      voice_data = 18'($urandom);
      req_cyc    = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [17:0] d, input int dly);
    for (int i = 0; i < 16; i++) begin
      data_tbl[i] = d;
      dly_tbl[i]  = dly;
    end
  endtask

  // ovr_mode: 0 none, 1 random point in frame, 2 tick while in DONE, 3 fixed cycle 3
  task automatic frame(input string tag, input logic [15:0] mask, input int ovr_mode);
    int exp_lat = 2, exp_to = 0, exp_ov, sum = 0, exp_n = 0;
    int lat = 0, to_seen = 0, ov_seen = 0, start, ovr_at;
    logic [23:0] exp_mix;
    logic [63:0] exp_sig = '0, obs_sig = '0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        exp_sig = {exp_sig[59:0], 4'(i)};
        exp_n++;
        if (dly_tbl[i] < 64) begin
          exp_lat += dly_tbl[i] + 2;
          sum     += int'($signed(data_tbl[i]));
        end else begin
          exp_lat += 65;
          exp_to++;
        end
      end
    end
    exp_mix = 24'(sum * 4);
    case (ovr_mode)
      1: ovr_at = $urandom_range(exp_lat, 1);
      2: ovr_at = exp_lat;
      3: ovr_at = 3;
      default: ovr_at = -1;
    endcase
    exp_ov = (ovr_at > 0) ? 1 : 0;
    start = visits.size();
    @(posedge clk); #1;
    sample_tick  = 1'b1;
    voice_active = mask;
    while (lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      sample_tick  = (lat == ovr_at);
      voice_active = 16'($urandom);
      if (timeout_err) to_seen++;
      if (overrun) ov_seen++;
      if (mix_valid) break;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " mix_out"}, 64'(mix_out), 64'(exp_mix));
    @(posedge clk); #1;
    sample_tick = 1'b0;
    if (overrun) ov_seen++;
    check({tag, " valid_pulse"}, 64'(mix_valid), 64'(0));
    check({tag, " busy_drop"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    check({tag, " no_restart"}, 64'(busy), 64'(0));
    check({tag, " mix_hold"}, 64'(mix_out), 64'(exp_mix));
    check({tag, " timeouts"}, 64'(to_seen), 64'(exp_to));
    check({tag, " overruns"}, 64'(ov_seen), 64'(exp_ov));
    for (int j = start; j < visits.size(); j++) obs_sig = {obs_sig[59:0], 4'(visits[j])};
    check({tag, " visit_count"}, 64'(visits.size() - start), 64'(exp_n));
    check({tag, " visit_order"}, obs_sig, exp_sig);
    last_mix = exp_mix;
  endtask

  initial begin
    fill(18'h04000, 0);
    #12;
    check("rst mix_out", 64'(mix_out), 64'(0));
    check("rst mix_valid", 64'(mix_valid), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst voice_req", 64'(voice_req), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    fill(18'h04000, 0);
    frame("full_bank", 16'hFFFF, 0);
    data_tbl[0] = 18'h04000;
    data_tbl[2] = 18'h32000;
    frame("sparse", 16'h0005, 0);
    fill(18'h20000, 0);
    frame("most_neg", 16'hFFFF, 0);
    fill(18'h1FFFF, 0);
    frame("most_pos", 16'hFFFF, 0);
    frame("mask_zero", 16'h0000, 0);
    fill(18'h04000, 1);
    dly_tbl[3] = 1000;
    frame("timeout_v3", 16'h001F, 0);
    fill(18'h02000, 0);
    dly_tbl[0] = 63;
    dly_tbl[1] = 64;
    frame("tmo_boundary", 16'h0003, 0);
    fill(18'h3C000, 2);
    frame("overrun_mid", 16'h00F0, 3);
    frame("overrun_done", 16'h0101, 2);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) begin
        data_tbl[i] = 18'($urandom);
        dly_tbl[i]  = ($urandom_range(7, 0) == 0) ? 100 : int'($urandom_range(3, 0));
      end
      frame("random", 16'($urandom), int'($urandom_range(1, 0)));
    end

    fill(18'h01000, 0);
    dly_tbl[0] = 30;
    frame("pre_reset", 16'h0006, 0);
    @(posedge clk); #1;
    sample_tick  = 1'b1;
    voice_active = 16'hFFFF;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("abort in_req", 64'(voice_req), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort voice_req", 64'(voice_req), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort mix_valid", 64'(mix_valid), 64'(0));
    check("abort mix_out", 64'(mix_out), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill(18'h05000, 0);
    data_tbl[9] = 18'h3F000;
    frame("post_reset", 16'h0300, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
